pinmux_cfg: RTL and testbench
=============================

PINMUX_CFG -- requirements
Module: pinmux_cfg

Interface
REQ-001 The block SHALL have parameter NPads, default 64, meaning number of muxable pads (1..128).
REQ-002 The block SHALL have parameter NPeriphOut, default 64, meaning number of peripheral output/enable pairs (1..255).
REQ-003 The block SHALL have parameter NPeriphIn, default 48, meaning number of peripheral inputs (1..127).
REQ-004 The block SHALL have parameter FiltCnt, default 8, meaning consecutive stable cycles required by an enabled input filter (2..255).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset, with ports clk_sys_i (in, 1, system clock) and rst_sys_i (in, 1, reset).
REQ-006 The block SHALL have port cfg_req_i (in, 1): config access request.
REQ-007 The block SHALL have port cfg_we_i (in, 1): 1 = write, 0 = read.
REQ-008 The block SHALL have port cfg_addr_i (in, 8): register address.
REQ-009 The block SHALL have port cfg_wdata_i (in, 32): write data.
REQ-010 The block SHALL have port cfg_gnt_o (out, 1): request accepted.
REQ-011 The block SHALL have port cfg_rvalid_o (out, 1): response valid.
REQ-012 The block SHALL have port cfg_rdata_o (out, 32): read data.
REQ-013 The block SHALL have port cfg_err_o (out, 1): response error, qualified by cfg_rvalid_o.
REQ-014 The block SHALL have port periph_out_i (in, NPeriphOut): peripheral output values.
REQ-015 The block SHALL have port periph_oe_i (in, NPeriphOut): peripheral output enables.
REQ-016 The block SHALL have port periph_in_o (out, NPeriphIn): inputs delivered to peripherals.
REQ-017 The block SHALL have port pad_in_i (in, NPads): raw pad inputs, asynchronous.
REQ-018 The block SHALL have port pad_out_o (out, NPads): pad output values.
REQ-019 The block SHALL have port pad_oe_o (out, NPads): pad output enables.

Function
REQ-020 The config port SHALL be always ready: cfg_gnt_o = cfg_req_i, combinational.
REQ-021 Each granted access SHALL produce exactly one cfg_rvalid_o pulse on the next cycle; back-to-back accesses SHALL be supported every cycle.
REQ-022 The register map SHALL be: OUTSEL[p] at 0x00+p (p < NPads), 8-bit sel; INSEL[i] at 0x80+i (i < NPeriphIn), bits[7:0] sel and bit[8] filter enable; LOCK at 0xFF, bit[0].
REQ-023 A read SHALL return the register value zero-extended on cfg_rdata_o with the rvalid pulse; unmapped addresses SHALL read 0 with cfg_err_o=1.
REQ-024 cfg_rdata_o SHALL be 0 whenever cfg_rvalid_o=0 and for every write response.
REQ-025 A write SHALL update the register on the clock edge of the grant cycle, and a read in the following cycle SHALL return the new value.
REQ-026 Writes to unmapped addresses SHALL be ignored with cfg_err_o=1.
REQ-027 A LOCK write with wdata[0]=1 SHALL set lock; lock is sticky and SHALL clear only on reset; a LOCK write with wdata[0]=0 SHALL have no effect.
REQ-028 While lock=1, writes to OUTSEL/INSEL SHALL be dropped with cfg_err_o=1, and reads SHALL be unaffected.
REQ-029 Pad output: for OUTSEL[p]=0, pad_out_o[p]=0 and pad_oe_o[p]=0.
REQ-030 Pad output: for 1 <= OUTSEL[p] <= NPeriphOut, pad p SHALL drive periph_out_i/periph_oe_i[sel-1], combinationally from the register.
REQ-031 Pad output: for OUTSEL[p] > NPeriphOut, pad p SHALL behave as sel=0.
REQ-032 One pad output SHALL be permitted to be selected by many pads.
REQ-033 Every pad input SHALL pass through a 2-flop synchronizer (sync[p]) before use.
REQ-034 Peripheral input: for INSEL[i].sel=0 or > NPads, periph_in_o[i]=0.
REQ-035 Peripheral input: otherwise, with the filter disabled, periph_in_o[i]=sync[sel-1], giving 2 cycles of latency from pad_in_i.
REQ-036 With the filter enabled, per-input counter cnt (8 bits) and held value filt SHALL apply.
REQ-037 Each cycle with sync != filt SHALL increment cnt; each cycle with sync == filt SHALL clear cnt.
REQ-038 When cnt would reach FiltCnt, filt SHALL load sync and cnt SHALL clear; periph_in_o[i]=filt.
REQ-039 A glitch shorter than FiltCnt cycles SHALL never propagate through an enabled filter.
REQ-040 Writing INSEL[i] (sel or enable change) SHALL clear cnt[i] and load filt[i] with the newly selected sync value at that edge.
REQ-041 While the filter is disabled, filt SHALL track the selected sync every cycle.

Reset
REQ-042 Reset SHALL clear to 0 all OUTSEL, INSEL, lock, synchronizer flops, filt and cnt.
REQ-043 After reset, pad_out_o=0, pad_oe_o=0, periph_in_o=0, cfg_rvalid_o=0, cfg_err_o=0 and cfg_rdata_o=0.
REQ-044 Reset asserted mid-access SHALL suppress that access's response.

Verification
REQ-045 Write OUTSEL[5]=3 and drive periph_out_i[2]=1, periph_oe_i[2]=1 -> pad_out_o[5]=1 and pad_oe_o[5]=1 in the cycle after the write; all other pads 0.
REQ-046 Write INSEL[0]=0x00A (sel=10, filter off) and pulse pad_in_i[9] high -> periph_in_o[0] rises exactly 2 cycles after pad_in_i.
REQ-047 Write INSEL[1]=0x10A with FiltCnt=8; apply a 7-cycle high then an 8-cycle high on pad_in_i[9] -> no change on the 7-cycle pulse, periph_in_o[1]=1 after the 8th stable cycle.
REQ-048 Write LOCK=1, then OUTSEL[0]=1 -> cfg_err_o=1 and a read of OUTSEL[0] returns 0; reset then clears lock.
REQ-049 Read 0x7F with NPads=64 -> cfg_rvalid_o=1, cfg_err_o=1, cfg_rdata_o=0; a write with OUTSEL[0]=200 gives pad 0 out=0 and oe=0.
REQ-050 Assert rst_sys_i in the cycle of a granted read -> no cfg_rvalid_o pulse follows, and all outputs are 0.

Source files
------------

// File: rtl/pinmux_cfg.sv
// pinmux_cfg
// Pad multiplexer with a small register-mapped configuration port.
//
// Each pad output picks one peripheral output/enable pair through OUTSEL[p].
// Each peripheral input picks one synchronized pad through INSEL[i]. The pad
// can optionally pass through a glitch filter that needs FiltCnt consecutive
// differing samples before it changes. A sticky LOCK bit freezes the mux
// configuration until the next reset.
//
// Ports
//   clk_sys_i, rst_sys_i   system clock, synchronous active-high reset
//   cfg_req_i/cfg_we_i     access request / write strobe (1 = write)
//   cfg_addr_i/cfg_wdata_i register address / write data
//   cfg_gnt_o              grant, equal to cfg_req_i (always ready)
//   cfg_rvalid_o           one-cycle response pulse after each grant
//   cfg_rdata_o            read data, 0 except on a read response
//   cfg_err_o              response error (unmapped, or blocked by lock)
//   periph_out_i/oe_i      peripheral output values / enables
//   periph_in_o            inputs delivered to peripherals
//   pad_in_i               raw asynchronous pad inputs
//   pad_out_o/pad_oe_o     pad output values / enables
//
// Register map
//   0x00+p  OUTSEL[p]  [7:0] sel (0 = off, 1..NPeriphOut = periph sel-1)
//   0x80+i  INSEL[i]   [7:0] sel (0 = off, 1..NPads = pad sel-1), [8] filter
//   0xFF    LOCK       [0]   write 1 to lock (sticky until reset)
module pinmux_cfg #(
    parameter int NPads      = 64,
    parameter int NPeriphOut = 64,
    parameter int NPeriphIn  = 48,
    parameter int FiltCnt    = 8
) (
    input  logic                  clk_sys_i,
    input  logic                  rst_sys_i,
    input  logic                  cfg_req_i,
    input  logic                  cfg_we_i,
    input  logic [7:0]            cfg_addr_i,
    input  logic [31:0]           cfg_wdata_i,
    output logic                  cfg_gnt_o,
    output logic                  cfg_rvalid_o,
    output logic [31:0]           cfg_rdata_o,
    output logic                  cfg_err_o,
    input  logic [NPeriphOut-1:0] periph_out_i,
    input  logic [NPeriphOut-1:0] periph_oe_i,
    output logic [NPeriphIn-1:0]  periph_in_o,
    input  logic [NPads-1:0]      pad_in_i,
    output logic [NPads-1:0]      pad_out_o,
    output logic [NPads-1:0]      pad_oe_o
);

    localparam logic [8:0] FILT_TGT = 9'(FiltCnt);

    // Configuration state
    logic [7:0]           r_outsel   [NPads];
    logic [7:0]           r_insel    [NPeriphIn];
    logic [NPeriphIn-1:0] r_insel_fen;
    logic                 r_lock;

    // Input path state
    logic [NPads-1:0]     r_sync1;
    logic [NPads-1:0]     r_sync2;
    logic [NPeriphIn-1:0] r_filt;
    logic [7:0]           r_cnt      [NPeriphIn];

    // Response state
    logic                 r_rvalid;
    logic                 r_err;
    logic [31:0]          r_rdata;

    // Address decode
    logic [6:0]           w_idx;
    logic                 w_hit_out;
    logic                 w_hit_in;
    logic                 w_hit_lock;
    logic                 w_wr;
    logic                 w_wr_ok;
    logic                 w_err;
    logic [31:0]          w_rd_val;
    logic [NPads-1:0]     w_out_we;
    logic [NPeriphIn-1:0] w_in_we;
    logic                 w_unused;

    // Sources widened to 256 entries so an 8-bit sel indexes them directly:
    // entry 0 and everything past the real sources read as 0, which gives
    // the "off" behaviour for sel=0 and out-of-range selects for free.
    logic [255:0]         w_pout_ext;
    logic [255:0]         w_poe_ext;
    logic [255:0]         w_sync_ext;
    logic [NPeriphIn-1:0] w_sel_sync;

    assign w_idx      = cfg_addr_i[6:0];
    assign w_hit_out  = !cfg_addr_i[7] && (int'(w_idx) < NPads);
    assign w_hit_in   = cfg_addr_i[7] && (int'(w_idx) < NPeriphIn);
    assign w_hit_lock = (cfg_addr_i == 8'hFF);
    assign w_wr       = cfg_req_i && cfg_we_i;
    assign w_wr_ok    = w_wr && !r_lock;
    assign w_err      = !(w_hit_out || w_hit_in || w_hit_lock) ||
                        (cfg_we_i && r_lock && (w_hit_out || w_hit_in));
    assign w_unused   = ^cfg_wdata_i[31:9];

    assign cfg_gnt_o    = cfg_req_i;
    assign cfg_rvalid_o = r_rvalid;
    assign cfg_err_o    = r_err;
    assign cfg_rdata_o  = r_rdata;

    always_comb begin
        w_rd_val = '0;
        for (int p = 0; p < NPads; p++) begin
            if (w_hit_out && int'(w_idx) == p) w_rd_val = {24'd0, r_outsel[p]};
        end
        for (int i = 0; i < NPeriphIn; i++) begin
            if (w_hit_in && int'(w_idx) == i) w_rd_val = {23'd0, r_insel_fen[i], r_insel[i]};
        end
        if (w_hit_lock) w_rd_val = {31'd0, r_lock};
    end

    always_comb begin
        w_pout_ext = '0;
        w_poe_ext  = '0;
        w_sync_ext = '0;
        w_pout_ext[NPeriphOut:1] = periph_out_i;
        w_poe_ext[NPeriphOut:1]  = periph_oe_i;
        w_sync_ext[NPads:1]      = r_sync2;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NPads; gi++) begin : g_pad
            assign w_out_we[gi]  = w_wr_ok && w_hit_out && (int'(w_idx) == gi);
            assign pad_out_o[gi] = w_pout_ext[r_outsel[gi]];
            assign pad_oe_o[gi]  = w_poe_ext[r_outsel[gi]];
        end
        for (gi = 0; gi < NPeriphIn; gi++) begin : g_pin
            assign w_in_we[gi]    = w_wr_ok && w_hit_in && (int'(w_idx) == gi);
            assign w_sel_sync[gi] = w_sync_ext[r_insel[gi]];
            // An invalid sel makes the selected sync 0 and the filter is
            // loaded from it on the write, so filt is 0 there as well.
            assign periph_in_o[gi] = r_insel_fen[gi] ? r_filt[gi] : w_sel_sync[gi];
        end
    endgenerate

    // Config port response and lock
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_lock   <= 1'b0;
        end else begin
            r_rvalid <= cfg_req_i;
            r_err    <= cfg_req_i && w_err;
            r_rdata  <= (cfg_req_i && !cfg_we_i) ? w_rd_val : 32'd0;
            if (w_wr && w_hit_lock && cfg_wdata_i[0]) r_lock <= 1'b1;
        end
    end

    // Pad input synchronizers
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pad_in_i;
            r_sync2 <= r_sync1;
        end
    end

    // OUTSEL registers
    always_ff @(posedge clk_sys_i) begin
        for (int p = 0; p < NPads; p++) begin
            if (rst_sys_i) begin
                r_outsel[p] <= '0;
            end else if (w_out_we[p]) begin
                r_outsel[p] <= cfg_wdata_i[7:0];
            end
        end
    end

    // INSEL registers and input filters
    always_ff @(posedge clk_sys_i) begin
        for (int i = 0; i < NPeriphIn; i++) begin
            if (rst_sys_i) begin
                r_insel[i]     <= '0;
                r_insel_fen[i] <= 1'b0;
                r_filt[i]      <= 1'b0;
                r_cnt[i]       <= '0;
            end else if (w_in_we[i]) begin
                // Restart the filter from the newly selected pad's value
                r_insel[i]     <= cfg_wdata_i[7:0];
                r_insel_fen[i] <= cfg_wdata_i[8];
                r_filt[i]      <= w_sync_ext[cfg_wdata_i[7:0]];
                r_cnt[i]       <= '0;
            end else if (!r_insel_fen[i]) begin
                r_filt[i] <= w_sel_sync[i];
                r_cnt[i]  <= '0;
            end else if (w_sel_sync[i] != r_filt[i]) begin
                if (({1'b0, r_cnt[i]} + 9'd1) == FILT_TGT) begin
                    r_filt[i] <= w_sel_sync[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end else begin
                r_cnt[i] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pinmux_cfg.sv
// tb_pinmux_cfg
// Directed scenarios with literal expectations, followed by a randomized run.
// A behavioural model (register arrays, pad sample history, and a sliding
// window of selected samples per filtered input) predicts every output and
// is compared against the DUT on each falling edge.
module tb_pinmux_cfg;

    localparam int NP   = 64;
    localparam int NO   = 64;
    localparam int NI   = 48;
    localparam int FILT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          we;
    logic [7:0]    addr;
    logic [31:0]   wdata;
    logic          gnt;
    logic          rvalid;
    logic [31:0]   rdata;
    logic          err;
    logic [NO-1:0] pout;
    logic [NO-1:0] poe;
    logic [NI-1:0] pin;
    logic [NP-1:0] pad_in;
    logic [NP-1:0] pad_out;
    logic [NP-1:0] pad_oe;

    int checks = 0;
    int errors = 0;

    pinmux_cfg #(
        .NPads      (NP),
        .NPeriphOut (NO),
        .NPeriphIn  (NI),
        .FiltCnt    (FILT)
    ) dut (
        .clk_sys_i    (clk),
        .rst_sys_i    (rst),
        .cfg_req_i    (req),
        .cfg_we_i     (we),
        .cfg_addr_i   (addr),
        .cfg_wdata_i  (wdata),
        .cfg_gnt_o    (gnt),
        .cfg_rvalid_o (rvalid),
        .cfg_rdata_o  (rdata),
        .cfg_err_o    (err),
        .periph_out_i (pout),
        .periph_oe_i  (poe),
        .periph_in_o  (pin),
        .pad_in_i     (pad_in),
        .pad_out_o    (pad_out),
        .pad_oe_o     (pad_oe)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          m_outsel [NP];
    int          m_isel   [NI];
    bit          m_fen    [NI];
    bit          m_filt   [NI];
    logic [31:0] m_hist   [NI];
    int          m_nhist  [NI];
    bit          m_lock;
    logic [NP-1:0] m_d1;
    logic [NP-1:0] m_d2;
    bit          m_rvalid;
    bit          m_err;
    logic [31:0] m_rdata;

    // Pad value as seen two clock edges after it was sampled
    function automatic bit sync_of(input int s);
        if (s >= 1 && s <= NP) return m_d2[s-1];
        return 1'b0;
    endfunction

    function automatic logic [NP-1:0] exp_pad(input logic [NO-1:0] src);
        logic [NP-1:0] r;
        r = '0;
        for (int p = 0; p < NP; p++) begin
            if (m_outsel[p] >= 1 && m_outsel[p] <= NO) r[p] = src[m_outsel[p]-1];
        end
        return r;
    endfunction

    function automatic logic [NI-1:0] exp_pin();
        logic [NI-1:0] r;
        r = '0;
        for (int i = 0; i < NI; i++) begin
            if (m_isel[i] >= 1 && m_isel[i] <= NP)
                r[i] = m_fen[i] ? m_filt[i] : sync_of(m_isel[i]);
        end
        return r;
    endfunction

    task automatic model_edge();
        int a;
        int idx;
        bit hout;
        bit hin;
        bit hlock;
        bit wr_ok;
        bit v;
        logic [31:0] mask;
        if (rst) begin
            for (int p = 0; p < NP; p++) m_outsel[p] = 0;
            for (int i = 0; i < NI; i++) begin
                m_isel[i] = 0; m_fen[i] = 0; m_filt[i] = 0; m_hist[i] = 0; m_nhist[i] = 0;
            end
            m_lock = 0; m_d1 = '0; m_d2 = '0;
            m_rvalid = 0; m_err = 0; m_rdata = 0;
            return;
        end
        a     = int'(addr);
        idx   = a % 128;
        hout  = (a < NP);
        hin   = (a >= 128) && (idx < NI);
        hlock = (a == 255);
        wr_ok = req && we && !m_lock;

        m_rvalid = req;
        m_err    = 0;
        m_rdata  = 0;
        if (req) begin
            m_err = !(hout || hin || hlock) || (we && m_lock && (hout || hin));
            if (!we) begin
                if (hout)       m_rdata = 32'(m_outsel[idx]);
                else if (hin)   m_rdata = 32'(m_isel[idx]) | (m_fen[idx] ? 32'h100 : 32'h0);
                else if (hlock) m_rdata = 32'(m_lock);
            end
        end

        mask = (32'd1 << FILT) - 32'd1;
        for (int i = 0; i < NI; i++) begin
            if (wr_ok && hin && idx == i) begin
                m_isel[i]  = int'(wdata[7:0]);
                m_fen[i]   = wdata[8];
                m_filt[i]  = sync_of(m_isel[i]);
                m_hist[i]  = 0;
                m_nhist[i] = 0;
            end else if (!m_fen[i]) begin
                m_filt[i]  = sync_of(m_isel[i]);
                m_nhist[i] = 0;
            end else begin
                // Change only after FILT consecutive samples that all
                // differ from the held value
                v = sync_of(m_isel[i]);
                m_hist[i] = {m_hist[i][30:0], v};
                m_nhist[i]++;
                if (m_nhist[i] >= FILT && (m_hist[i] & mask) == (m_filt[i] ? 32'd0 : mask))
                    m_filt[i] = v;
            end
        end

        if (wr_ok && hout) m_outsel[idx] = int'(wdata[7:0]);
        if (req && we && hlock && wdata[0]) m_lock = 1;

        m_d2 = m_d1;
        m_d1 = pad_in;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("gnt", 64'(gnt), 64'(req));
        chk("rvalid", 64'(rvalid), 64'(m_rvalid));
        if (m_rvalid) chk("err", 64'(err), 64'(m_err));
        chk("rdata", 64'(rdata), 64'(m_rdata));
        chk("pad_out", 64'(pad_out), 64'(exp_pad(pout)));
        chk("pad_oe", 64'(pad_oe), 64'(exp_pad(poe)));
        chk("periph_in", 64'(pin), 64'(exp_pin()));
        if (rvalid === 1'b1)
            $display("rsp t=%0t rdata=%h err=%b", $time, rdata, err);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        cyc();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        req = 1'b1; we = 1'b0; addr = a; wdata = '0;
        cyc();
        req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        logic [31:0] w;
        logic [31:0] u0;
        logic [31:0] u1;

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        pout = '0; poe = '0; pad_in = '0;
        cyc();
        cyc();
        chk("rst_pad_out", 64'(pad_out), 64'd0);
        chk("rst_periph_in", 64'(pin), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        cyc();

        // Pad 5 follows peripheral 2
        pout = 64'h4; poe = 64'h4;
        wr(8'h05, 32'd3);
        chk("outsel_pad_out", 64'(pad_out), 64'h20);
        chk("outsel_pad_oe", 64'(pad_oe), 64'h20);

        // Unfiltered input: 2-cycle latency from pad 9
        wr(8'h80, 32'h00A);
        cyc(); cyc();
        pad_in[9] = 1'b1;
        cyc();
        chk("unfilt_1cyc", 64'(pin[0]), 64'd0);
        cyc();
        chk("unfilt_2cyc", 64'(pin[0]), 64'd1);
        pad_in[9] = 1'b0;
        repeat (4) cyc();

        // Filtered input: 7-cycle pulse rejected, 8-cycle pulse accepted
        wr(8'h81, 32'h10A);
        repeat (4) cyc();
        pad_in[9] = 1'b1;
        repeat (7) begin
            cyc();
            chk("filt_short", 64'(pin[1]), 64'd0);
        end
        pad_in[9] = 1'b0;
        repeat (12) begin
            cyc();
            chk("filt_short_after", 64'(pin[1]), 64'd0);
        end
        pad_in[9] = 1'b1;
        repeat (9) begin
            cyc();
            chk("filt_long_wait", 64'(pin[1]), 64'd0);
        end
        cyc();
        chk("filt_long_rise", 64'(pin[1]), 64'd1);
        rd(8'h81);
        chk("insel_readback", 64'(rdata), 64'h10A);

        // Unmapped read and out-of-range select
        rd(8'h7F);
        chk("unmapped_rvalid", 64'(rvalid), 64'd1);
        chk("unmapped_err", 64'(err), 64'd1);
        chk("unmapped_rdata", 64'(rdata), 64'd0);
        pout = '1; poe = '1;
        wr(8'h00, 32'd200);
        chk("sel200_out", 64'(pad_out[0]), 64'd0);
        chk("sel200_oe", 64'(pad_oe[0]), 64'd0);
        rd(8'h00);
        chk("sel200_read", 64'(rdata), 64'd200);

        // Lock
        wr(8'h00, 32'd0);
        wr(8'hFF, 32'd1);
        chk("lock_wr_err", 64'(err), 64'd0);
        wr(8'h00, 32'd1);
        chk("locked_wr_err", 64'(err), 64'd1);
        rd(8'h00);
        chk("locked_read", 64'(rdata), 64'd0);
        rd(8'hFF);
        chk("lock_read", 64'(rdata), 64'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        wr(8'h00, 32'd1);
        chk("unlocked_wr_err", 64'(err), 64'd0);
        rd(8'h00);
        chk("unlocked_read", 64'(rdata), 64'd1);

        // Reset during a granted read
        req = 1'b1; we = 1'b0; addr = 8'h00; rst = 1'b1;
        cyc();
        chk("rst_mid_rvalid", 64'(rvalid), 64'd0);
        chk("rst_mid_pad_out", 64'(pad_out), 64'd0);
        chk("rst_mid_pad_oe", 64'(pad_oe), 64'd0);
        chk("rst_mid_pin", 64'(pin), 64'd0);
        rst = 1'b0; req = 1'b0;
        cyc();
        chk("rst_mid_no_pulse", 64'(rvalid), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            req = ($urandom_range(0, 1) == 1);
            we  = ($urandom_range(0, 1) == 1);
            r = int'($urandom_range(0, 99));
            if (r < 45)      addr = 8'($urandom_range(0, 70));
            else if (r < 90) addr = 8'(128 + $urandom_range(0, 52));
            else if (r < 92) addr = 8'hFF;
            else             addr = 8'($urandom_range(0, 255));
            w = $urandom;
            if ($urandom_range(0, 9) == 0) w[7:0] = 8'($urandom_range(0, 255));
            else                           w[7:0] = 8'($urandom_range(0, 66));
            if (addr == 8'hFF) w[0] = ($urandom_range(0, 199) == 0);
            wdata = w;
            u0 = $urandom; u1 = $urandom;
            pout = {u0, u1};
            u0 = $urandom; u1 = $urandom;
            poe = {u0, u1};
            for (int b = 0; b < NP; b++) begin
                if ($urandom_range(0, 15) == 0) pad_in[b] = ~pad_in[b];
            end
            cyc();
        end
        rst = 1'b0; req = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
